pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter ADDR_SIZE, 10, PC/branch-target width.
REQ-002 SHALL have parameter REG_SEL, 5, register-select width.
REQ-003 SHALL have parameter MEM_TIMEOUT, 255, maximum dmem wait cycles before error; CNT_W = clog2(MEM_TIMEOUT+1).
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports id_rs1, id_rs2  in  REG_SEL  sources of instruction in ID.
REQ-007 SHALL have ports id_use_rs1, id_use_rs2  in  1  source actually read.
REQ-008 SHALL have ports ex_rd  in  REG_SEL and ex_mem_read  in  1, both from ID/EX outputs.
REQ-009 SHALL have ports mem_branch, mem_alu_zero, mem_jump, mem_read, mem_write  in  1, and mem_branch_target  in  ADDR_SIZE, all from EX/MEM outputs.
REQ-010 SHALL have port dmem_ready  in  1  data memory completes the access this cycle.
REQ-011 SHALL have port dmem_req  out  1  data memory access request.
REQ-012 SHALL have ports pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1  hold the register.
REQ-013 SHALL have ports if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1  load a bubble.
REQ-014 SHALL have ports pc_sel  out  1 and pc_target  out  ADDR_SIZE  PC redirect select/value.
REQ-015 SHALL have ports mem_err  out  1 (sticky timeout) and stall_cnt  out  16 (stall-cycle counter).

Function
REQ-016 SHALL compute taken = (mem_branch & mem_alu_zero) | mem_jump, combinationally.
REQ-017 SHALL compute mem_op = mem_read | mem_write; dmem_req = mem_op & (state != ERR).
REQ-018 SHALL compute mem_stall = (dmem_req & ~dmem_ready) | (state == ERR); zero-wait access (ready in the request cycle) produces no stall.
REQ-019 SHALL detect load_use = ex_mem_read & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
REQ-020 SHALL apply priority mem_stall > taken > load_use > none.
REQ-021 mem_stall SHALL assert pc_stall, if_id_stall, id_ex_stall, ex_mem_stall and mem_wb_flush; all other flushes 0, pc_sel 0.
REQ-022 taken (no mem_stall) SHALL assert pc_sel, pc_target = mem_branch_target, and if_id_flush, id_ex_flush, ex_mem_flush for exactly that cycle; no stalls.
REQ-023 load_use (no mem_stall, no taken) SHALL assert pc_stall, if_id_stall and id_ex_flush for one cycle.
REQ-024 SHALL otherwise drive all stall/flush/pc_sel 0 and pc_target 0.
REQ-025 FSM states IDLE, WAIT, ERR; IDLE->WAIT when dmem_req & ~dmem_ready; WAIT->IDLE when dmem_ready; WAIT->ERR when wait count reaches MEM_TIMEOUT with ~dmem_ready; ERR exits only by reset.
REQ-026 SHALL clear the CNT_W-bit wait counter on entry to WAIT and increment it each WAIT cycle; it shall never wrap.
REQ-027 SHALL assert mem_err while in ERR; all stalls held, dmem_req 0.
REQ-028 SHALL increment stall_cnt each cycle pc_stall is 1, saturating at 16'hFFFF.

Reset
REQ-029 Reset low SHALL immediately force state IDLE, wait counter 0, stall_cnt 0, mem_err 0; combinational outputs follow inputs per REQ-016..024.
REQ-030 Reset asserted during WAIT SHALL abandon the access; no pending state survives reset.

Structure
REQ-031 SHALL place state encoding (IDLE=2'd0, WAIT=2'd1, ERR=2'd2) and default parameter values in the shared core package.
REQ-032 SHALL implement as a single module; hazard_detect (combinational REQ-019) MAY be a sub-module.

Verification
REQ-033 Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> pc_stall=if_id_stall=id_ex_flush=1 one cycle, stall_cnt=1.
REQ-034 Load-use to x0: ex_rd=0, id_rs1=0 -> no stall, no flush.
REQ-035 Branch: mem_branch=1, mem_alu_zero=1, target 10'h040 -> pc_sel=1, pc_target=10'h040, three flushes, one cycle.
REQ-036 Memory wait: mem_read=1, dmem_ready low 3 cycles -> dmem_req 4 cycles, all stalls and mem_wb_flush 3 cycles, state IDLE after ready.
REQ-037 Timeout: MEM_TIMEOUT=4, dmem_ready held low -> ERR after 4 WAIT cycles, mem_err=1, dmem_req=0; rst low -> mem_err=0, stall_cnt=0.
REQ-038 Simultaneous: mem_stall with load_use -> no id_ex_flush; taken with load_use -> flushes only, pc_stall=0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Purpose: shared types, defaults and helpers for the pipeline hazard/stall controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipeline_ctrl_pkg;

  // Default parameter values for pipeline_ctrl
  localparam int unsigned ADDR_SIZE_DEF   = 10;
  localparam int unsigned REG_SEL_DEF     = 5;
  localparam int unsigned MEM_TIMEOUT_DEF = 255;

  // Width of the saturating stall-cycle counter
  localparam int unsigned STALL_CNT_W = 16;

  // Data-memory access tracker states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } mem_state_e;

  // Per-register hold controls
  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
  } stall_t;

  // Per-register bubble-insert controls
  typedef struct packed {
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } flush_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (v == {STALL_CNT_W{1'b1}}) ? v : v + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard.sv
// Purpose: load-use hazard detection between the ID instruction and a load in EX.
// Latency: purely combinational, same cycle.
// Backpressure: none; result feeds the stall/flush priority logic in the top.
module pipeline_ctrl_hazard #(
  parameter int unsigned REG_SEL = 5
) (
  input  logic [REG_SEL-1:0] id_rs1_i,
  input  logic [REG_SEL-1:0] id_rs2_i,
  input  logic               id_use_rs1_i,
  input  logic               id_use_rs2_i,
  input  logic [REG_SEL-1:0] ex_rd_i,
  input  logic               ex_mem_read_i,
  output logic               load_use_o
);

  logic rs1_hit;
  logic rs2_hit;
  logic rd_nonzero;

  // A load writing x0 never creates a real dependency
  always_comb begin
    rd_nonzero = (ex_rd_i != '0);
    rs1_hit    = id_use_rs1_i & (id_rs1_i == ex_rd_i);
    rs2_hit    = id_use_rs2_i & (id_rs2_i == ex_rd_i);
    load_use_o = ex_mem_read_i & rd_nonzero & (rs1_hit | rs2_hit);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Purpose: pipeline hazard controller: stalls, flushes, PC redirect and dmem wait tracking.
// Latency: stall/flush/redirect outputs are combinational in the same cycle; FSM and counters update on the clock.
// Backpressure: a dmem access not ready holds every stage and bubbles MEM/WB; a timed-out access stalls until reset.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_SIZE   = ADDR_SIZE_DEF,
  parameter int unsigned REG_SEL     = REG_SEL_DEF,
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  // ID stage sources
  input  logic [REG_SEL-1:0]     id_rs1,
  input  logic [REG_SEL-1:0]     id_rs2,
  input  logic                   id_use_rs1,
  input  logic                   id_use_rs2,
  // ID/EX register outputs
  input  logic [REG_SEL-1:0]     ex_rd,
  input  logic                   ex_mem_read,
  // EX/MEM register outputs
  input  logic                   mem_branch,
  input  logic                   mem_alu_zero,
  input  logic                   mem_jump,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [ADDR_SIZE-1:0]   mem_branch_target,
  // Data memory handshake
  input  logic                   dmem_ready,
  output logic                   dmem_req,
  // Pipeline register controls
  output logic                   pc_stall,
  output logic                   if_id_stall,
  output logic                   id_ex_stall,
  output logic                   ex_mem_stall,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   ex_mem_flush,
  output logic                   mem_wb_flush,
  output logic                   pc_sel,
  output logic [ADDR_SIZE-1:0]   pc_target,
  // Status
  output logic                   mem_err,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

  mem_state_e             state_q, state_d;
  logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d, wait_cnt_inc;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic   taken;
  logic   mem_op;
  logic   mem_stall;
  logic   load_use;
  stall_t stall;
  flush_t flush;

  pipeline_ctrl_hazard #(
    .REG_SEL (REG_SEL)
  ) u_hazard (
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_use_rs1_i  (id_use_rs1),
    .id_use_rs2_i  (id_use_rs2),
    .ex_rd_i       (ex_rd),
    .ex_mem_read_i (ex_mem_read),
    .load_use_o    (load_use)
  );

  // Resolve redirect and memory-request conditions from the EX/MEM register
  always_comb begin
    taken     = (mem_branch & mem_alu_zero) | mem_jump;
    mem_op    = mem_read | mem_write;
    dmem_req  = mem_op & (state_q != ERR);
    mem_stall = (dmem_req & ~dmem_ready) | (state_q == ERR);
  end

  // Priority select: memory stall over redirect over load-use bubble
  always_comb begin
    stall     = '0;
    flush     = '0;
    pc_sel    = 1'b0;
    pc_target = '0;
    if (mem_stall) begin
      // Freeze everything upstream of MEM and drop a bubble into WB
      stall        = '{pc: 1'b1, if_id: 1'b1, id_ex: 1'b1, ex_mem: 1'b1};
      flush.mem_wb = 1'b1;
    end else if (taken) begin
      // Squash the three younger instructions fetched down the wrong path
      pc_sel       = 1'b1;
      pc_target    = mem_branch_target;
      flush.if_id  = 1'b1;
      flush.id_ex  = 1'b1;
      flush.ex_mem = 1'b1;
    end else if (load_use) begin
      // Hold fetch/decode one cycle and bubble EX until the load data is forwardable
      stall.pc    = 1'b1;
      stall.if_id = 1'b1;
      flush.id_ex = 1'b1;
    end
  end

  // Fan the packed controls out to the individual ports
  always_comb begin
    pc_stall     = stall.pc;
    if_id_stall  = stall.if_id;
    id_ex_stall  = stall.id_ex;
    ex_mem_stall = stall.ex_mem;
    if_id_flush  = flush.if_id;
    id_ex_flush  = flush.id_ex;
    ex_mem_flush = flush.ex_mem;
    mem_wb_flush = flush.mem_wb;
    mem_err      = (state_q == ERR);
    stall_cnt    = stall_cnt_q;
  end

  // Access tracker next state: count wait cycles, give up after MEM_TIMEOUT
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    wait_cnt_inc = (wait_cnt_q == TIMEOUT_C) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
    unique case (state_q)
      IDLE: begin
        // Counter is kept clear so it starts at zero on entry to WAIT
        wait_cnt_d = '0;
        if (dmem_req & ~dmem_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_inc;
        if (dmem_ready) begin
          state_d = IDLE;
        end else if (wait_cnt_inc == TIMEOUT_C) begin
          state_d = ERR;
        end
      end
      ERR: begin
        // Only reset leaves the error state
        state_d = ERR;
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Stall-cycle statistic, saturating
  always_comb begin
    stall_cnt_d = stall.pc ? sat_inc(stall_cnt_q) : stall_cnt_q;
  end

  // State registers; reset drops any in-flight access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  localparam int AW  = 10;
  localparam int RW  = 5;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [RW-1:0] id_rs1, id_rs2, ex_rd;
  logic          id_use_rs1, id_use_rs2, ex_mem_read;
  logic          mem_branch, mem_alu_zero, mem_jump, mem_read, mem_write;
  logic [AW-1:0] mem_branch_target;
  logic          dmem_ready;
  logic          dmem_req;
  logic          pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic          if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic          pc_sel;
  logic [AW-1:0] pc_target;
  logic          mem_err;
  logic [15:0]   stall_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: is an access outstanding, how long it has waited, has it timed out
  bit m_waiting;
  bit m_err;
  int m_waited;
  int m_stall_cnt;
  // Expectations latched at the check point, used to advance the model on the edge
  bit e_pc_stall;
  bit e_mem_op;

  pipeline_ctrl #(
    .ADDR_SIZE   (AW),
    .REG_SEL     (RW),
    .MEM_TIMEOUT (TMO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .id_rs1            (id_rs1),
    .id_rs2            (id_rs2),
    .id_use_rs1        (id_use_rs1),
    .id_use_rs2        (id_use_rs2),
    .ex_rd             (ex_rd),
    .ex_mem_read       (ex_mem_read),
    .mem_branch        (mem_branch),
    .mem_alu_zero      (mem_alu_zero),
    .mem_jump          (mem_jump),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_branch_target (mem_branch_target),
    .dmem_ready        (dmem_ready),
    .dmem_req          (dmem_req),
    .pc_stall          (pc_stall),
    .if_id_stall       (if_id_stall),
    .id_ex_stall       (id_ex_stall),
    .ex_mem_stall      (ex_mem_stall),
    .if_id_flush       (if_id_flush),
    .id_ex_flush       (id_ex_flush),
    .ex_mem_flush      (ex_mem_flush),
    .mem_wb_flush      (mem_wb_flush),
    .pc_sel            (pc_sel),
    .pc_target         (pc_target),
    .mem_err           (mem_err),
    .stall_cnt         (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = '0; ex_mem_read = 0;
    mem_branch = 0; mem_alu_zero = 0; mem_jump = 0; mem_read = 0; mem_write = 0;
    mem_branch_target = '0; dmem_ready = 1;
  endtask

  // Compare all outputs against what the rules say for current inputs and model state
  task automatic check_now(input string ph);
    bit taken, req, mst, lu;
    logic [8:0]    ectl;
    logic [AW-1:0] etgt;
    taken = (mem_branch && mem_alu_zero) || mem_jump;
    e_mem_op = mem_read || mem_write;
    req   = e_mem_op && !m_err;
    mst   = (req && !dmem_ready) || m_err;
    lu    = ex_mem_read && (ex_rd != 0) &&
            ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    etgt  = '0;
    // {pc,if_id,id_ex,ex_mem stall, if_id,id_ex,ex_mem,mem_wb flush, pc_sel}
    if (mst)        ectl = 9'b1111_0001_0;
    else if (taken) begin ectl = 9'b0000_1110_1; etgt = mem_branch_target; end
    else if (lu)    ectl = 9'b1100_0100_0;
    else            ectl = 9'b0;
    e_pc_stall = ectl[8];
    chk({ph, ".ctl"}, 32'({pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, pc_sel}), 32'(ectl));
    chk({ph, ".dmem_req"}, 32'(dmem_req), 32'(req));
    chk({ph, ".pc_target"}, 32'(pc_target), 32'(etgt));
    chk({ph, ".mem_err"}, 32'(mem_err), 32'(m_err));
    chk({ph, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall_cnt));
  endtask

  task automatic model_edge();
    if (e_pc_stall && m_stall_cnt < 65535) m_stall_cnt++;
    if (!m_err) begin
      if (!m_waiting) begin
        if (e_mem_op && !dmem_ready) begin m_waiting = 1; m_waited = 0; end
      end else if (dmem_ready) begin
        m_waiting = 0;
      end else begin
        m_waited++;
        if (m_waited == TMO) begin m_err = 1; m_waiting = 0; end
      end
    end
  endtask

  // Called at a falling edge with inputs applied; returns at the next falling edge
  task automatic cycle(input string ph);
    #1;
    check_now(ph);
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset(input string ph);
    rst = 0;
    #1;
    m_waiting = 0; m_err = 0; m_waited = 0; m_stall_cnt = 0;
    check_now(ph);
    @(negedge clk);
    rst = 1;
  endtask

  int n_req, n_stall, n_wbf;

  initial begin
    set_idle();
    #2;
    do_reset("reset");
    chk("reset.stall_cnt0", 32'(stall_cnt), 32'd0);

    // Load-use on rs1
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    #1;
    chk("lu.pc_stall", 32'(pc_stall), 32'd1);
    chk("lu.id_ex_flush", 32'(id_ex_flush), 32'd1);
    cycle("lu");
    set_idle();
    #1;
    chk("lu.stall_cnt", 32'(stall_cnt), 32'd1);
    chk("lu.one_cycle", 32'(pc_stall), 32'd0);
    cycle("lu_after");

    // Load writing x0 is not a hazard
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    #1;
    chk("x0.stall_flush", 32'({pc_stall, if_id_stall, id_ex_flush}), 32'd0);
    cycle("x0");

    // Load-use through rs2 only
    set_idle();
    ex_mem_read = 1; ex_rd = 9; id_rs2 = 9; id_use_rs2 = 1; id_rs1 = 9;
    cycle("lu_rs2");
    id_use_rs2 = 0; id_use_rs1 = 0;
    cycle("lu_unused");

    // Taken branch
    set_idle();
    mem_branch = 1; mem_alu_zero = 1; mem_branch_target = 10'h040;
    #1;
    chk("br.pc_sel", 32'(pc_sel), 32'd1);
    chk("br.pc_target", 32'(pc_target), 32'h040);
    chk("br.flushes", 32'({if_id_flush, id_ex_flush, ex_mem_flush}), 32'h7);
    cycle("br");
    mem_alu_zero = 0;
    cycle("br_not_taken");
    set_idle();
    mem_jump = 1; mem_branch_target = 10'h3FF;
    cycle("jump");

    // Memory wait: 3 cycles not ready, then ready
    set_idle();
    n_req = 0; n_stall = 0; n_wbf = 0;
    for (int i = 0; i < 5; i++) begin
      mem_read   = (i < 4);
      dmem_ready = (i >= 3);
      #1;
      n_req   += int'(dmem_req);
      n_stall += int'(pc_stall && if_id_stall && id_ex_stall && ex_mem_stall);
      n_wbf   += int'(mem_wb_flush);
      cycle($sformatf("wait%0d", i));
    end
    chk("wait.req_cycles", 32'(n_req), 32'd4);
    chk("wait.stall_cycles", 32'(n_stall), 32'd3);
    chk("wait.wb_flush_cycles", 32'(n_wbf), 32'd3);
    // Back in IDLE: a zero-wait access produces no stall
    mem_write = 1; dmem_ready = 1;
    #1;
    chk("wait.idle_zero_wait", 32'(pc_stall), 32'd0);
    cycle("zero_wait");

    // Memory stall masks load-use; taken masks load-use
    set_idle();
    mem_read = 1; dmem_ready = 0;
    ex_mem_read = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
    #1;
    chk("sim.mst_no_idex_flush", 32'(id_ex_flush), 32'd0);
    cycle("sim_mst");
    dmem_ready = 1; mem_jump = 1; mem_branch_target = 10'h123;
    #1;
    chk("sim.taken_pc_stall", 32'(pc_stall), 32'd0);
    chk("sim.taken_flushes", 32'({if_id_flush, id_ex_flush, ex_mem_flush}), 32'h7);
    cycle("sim_taken");

    // Timeout into ERR, then reset clears
    set_idle();
    mem_read = 1; dmem_ready = 0;
    for (int i = 0; i < 5; i++) cycle($sformatf("tmo%0d", i));
    #1;
    chk("tmo.mem_err", 32'(mem_err), 32'd1);
    chk("tmo.dmem_req", 32'(dmem_req), 32'd0);
    dmem_ready = 1;
    cycle("err_hold");
    do_reset("tmo_reset");
    chk("tmo_reset.mem_err", 32'(mem_err), 32'd0);
    chk("tmo_reset.stall_cnt", 32'(stall_cnt), 32'd0);

    // Reset in the middle of a wait abandons the access
    set_idle();
    mem_read = 1; dmem_ready = 0;
    cycle("mid0");
    cycle("mid1");
    do_reset("mid_reset");
    dmem_ready = 1;
    cycle("mid_after");

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      id_rs1            = RW'($urandom_range(0, 3));
      id_rs2            = RW'($urandom_range(0, 3));
      ex_rd             = RW'($urandom_range(0, 3));
      id_use_rs1        = 1'($urandom);
      id_use_rs2        = 1'($urandom);
      ex_mem_read       = 1'($urandom);
      mem_branch        = ($urandom_range(0, 3) == 0);
      mem_alu_zero      = 1'($urandom);
      mem_jump          = ($urandom_range(0, 7) == 0);
      mem_read          = ($urandom_range(0, 3) == 0);
      mem_write         = ($urandom_range(0, 5) == 0);
      mem_branch_target = AW'($urandom);
      dmem_ready        = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 149) == 0) do_reset("rnd_reset");
      else cycle("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
